pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipelined CPU.
- Watches the IF/ID, ID/EX and EX/MEM stages and drives the stall and flush controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, multi-cycle data-memory access, taken-branch flushes and halt.
- Keeps saturating performance counters for stall cycles and flush events.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register 0 is hard-wired to zero, so it can never create a hazard.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (en && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, multi-cycle
// memory access, taken-branch flushes and halt, plus stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16,
  parameter int REG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             idex_mem_re,
  input  logic [REG_W-1:0] idex_dst,
  input  logic             exmem_mem_re,
  input  logic             exmem_mem_we,
  input  logic             exmem_br_taken,
  input  logic             exmem_hlt,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_ex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_ex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // The first MEM cycle is spent in RUN and the release cycle at wcnt==0.
  localparam logic [3:0] WCNT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic       MEM_STALL = (MEM_LAT > 1);

  state_e     r_state;
  logic [3:0] r_wcnt;

  state_e     w_state_next;
  logic [3:0] w_wcnt_next;
  logic       w_memop, w_lduse, w_flush_inc;
  logic       w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_ex;
  logic       w_flush_ifid, w_flush_idex, w_flush_ex, w_halted;

  assign w_memop = exmem_mem_re | exmem_mem_we;
  assign w_lduse = idex_mem_re && (idex_dst != REG_W'(ZERO_REG)) &&
                   ((id_use1 && (id_src1 == idex_dst)) ||
                    (id_use2 && (id_src2 == idex_dst)));

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_flush_inc  = 1'b0;
    w_stall_pc   = 1'b0;
    w_stall_ifid = 1'b0;
    w_stall_idex = 1'b0;
    w_stall_ex   = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_flush_ex   = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      RUN: begin
        if (exmem_hlt) begin
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_state_next = HALT;
        end else if (w_memop && MEM_STALL) begin
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
          w_stall_idex = 1'b1;
          w_stall_ex   = 1'b1;
          w_wcnt_next  = WCNT_LOAD;
          w_state_next = MEM_WAIT;
        end else if (exmem_br_taken) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_flush_ex   = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (w_lduse) begin
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
          w_flush_idex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (r_wcnt != 4'd0) begin
          w_stall_pc   = 1'b1;
          w_stall_ifid = 1'b1;
          w_stall_idex = 1'b1;
          w_stall_ex   = 1'b1;
          w_wcnt_next  = r_wcnt - 4'd1;
        end else begin
          // Release cycle: branch/halt of the finishing memory op are not acted on.
          w_state_next = RUN;
          if (w_lduse) begin
            w_stall_pc   = 1'b1;
            w_stall_ifid = 1'b1;
            w_flush_idex = 1'b1;
          end
        end
      end
      HALT: begin
        w_stall_pc   = 1'b1;
        w_stall_ifid = 1'b1;
        w_flush_idex = 1'b1;
        w_halted     = 1'b1;
      end
      default: begin
        w_state_next = RUN;
        w_wcnt_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  assign stall_pc   = w_stall_pc   & ~rst;
  assign stall_ifid = w_stall_ifid & ~rst;
  assign stall_idex = w_stall_idex & ~rst;
  assign stall_ex   = w_stall_ex   & ~rst;
  assign flush_ifid = w_flush_ifid & ~rst;
  assign flush_idex = w_flush_idex & ~rst;
  assign flush_ex   = w_flush_ex   & ~rst;
  assign halted     = w_halted     & ~rst;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .en  (stall_pc),
    .clk (clk),
    .rst (rst),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .en  (w_flush_inc & ~rst),
    .clk (clk),
    .rst (rst),
    .q   (flush_events)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: three configurations share one stimulus stream,
// each expected entry names the instance whose outputs it is checked against.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] id_src1, id_src2, idex_dst;
  logic       id_use1, id_use2, idex_mem_re;
  logic       exmem_mem_re, exmem_mem_we, exmem_br_taken, exmem_hlt;

  always #5 clk = ~clk;

  // ctrl vector: {stall_pc, stall_ifid, stall_idex, stall_ex, flush_ifid, flush_idex, flush_ex, halted}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_0100;
  localparam logic [7:0] MS   = 8'b1111_0000;
  localparam logic [7:0] BR   = 8'b0000_1110;
  localparam logic [7:0] HTR  = 8'b1100_1100;
  localparam logic [7:0] HT   = 8'b1100_0101;

  logic [7:0]  act_ctrl [3];
  logic [15:0] act_sc   [3];
  logic [15:0] act_fe   [3];
  logic [3:0]  c_sc, c_fe;

  // A: MEM_LAT=3, B: MEM_LAT=1, C: MEM_LAT=8 with 4-bit counters
  pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(16), .REG_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .idex_mem_re(idex_mem_re), .idex_dst(idex_dst),
    .exmem_mem_re(exmem_mem_re), .exmem_mem_we(exmem_mem_we),
    .exmem_br_taken(exmem_br_taken), .exmem_hlt(exmem_hlt),
    .stall_pc(act_ctrl[0][7]), .stall_ifid(act_ctrl[0][6]), .stall_idex(act_ctrl[0][5]),
    .stall_ex(act_ctrl[0][4]), .flush_ifid(act_ctrl[0][3]), .flush_idex(act_ctrl[0][2]),
    .flush_ex(act_ctrl[0][1]), .halted(act_ctrl[0][0]),
    .stall_cycles(act_sc[0]), .flush_events(act_fe[0])
  );

  pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(16), .REG_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .idex_mem_re(idex_mem_re), .idex_dst(idex_dst),
    .exmem_mem_re(exmem_mem_re), .exmem_mem_we(exmem_mem_we),
    .exmem_br_taken(exmem_br_taken), .exmem_hlt(exmem_hlt),
    .stall_pc(act_ctrl[1][7]), .stall_ifid(act_ctrl[1][6]), .stall_idex(act_ctrl[1][5]),
    .stall_ex(act_ctrl[1][4]), .flush_ifid(act_ctrl[1][3]), .flush_idex(act_ctrl[1][2]),
    .flush_ex(act_ctrl[1][1]), .halted(act_ctrl[1][0]),
    .stall_cycles(act_sc[1]), .flush_events(act_fe[1])
  );

  pipe_hazard_ctrl #(.MEM_LAT(8), .CNT_W(4), .REG_W(4)) dut_c (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .idex_mem_re(idex_mem_re), .idex_dst(idex_dst),
    .exmem_mem_re(exmem_mem_re), .exmem_mem_we(exmem_mem_we),
    .exmem_br_taken(exmem_br_taken), .exmem_hlt(exmem_hlt),
    .stall_pc(act_ctrl[2][7]), .stall_ifid(act_ctrl[2][6]), .stall_idex(act_ctrl[2][5]),
    .stall_ex(act_ctrl[2][4]), .flush_ifid(act_ctrl[2][3]), .flush_idex(act_ctrl[2][2]),
    .flush_ex(act_ctrl[2][1]), .halted(act_ctrl[2][0]),
    .stall_cycles(c_sc), .flush_events(c_fe)
  );

  assign act_sc[2] = {12'd0, c_sc};
  assign act_fe[2] = {12'd0, c_fe};

  typedef struct {
    int          sel;
    logic [7:0]  ctrl;
    logic [15:0] sc;
    logic [15:0] fe;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: one transaction per falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      if (act_ctrl[e.sel] !== e.ctrl)
        $display("FAIL %s ctrl: got %b expected %b", e.name, act_ctrl[e.sel], e.ctrl);
      else
        n_pass++;
      n_total++;
      if (act_sc[e.sel] !== e.sc || act_fe[e.sel] !== e.fe)
        $display("FAIL %s counters: got sc=%0d fe=%0d expected sc=%0d fe=%0d",
                 e.name, act_sc[e.sel], act_fe[e.sel], e.sc, e.fe);
      else
        n_pass++;
      $display("[%0t] dut%0d %s ctrl=%b sc=%0d fe=%0d", $time, e.sel, e.name,
               act_ctrl[e.sel], act_sc[e.sel], act_fe[e.sel]);
    end
  end

  task automatic exp(input int sel, input logic [7:0] ctrl, input int sc, input int fe,
                     input string name);
    exp_t e;
    e.sel = sel; e.ctrl = ctrl; e.sc = 16'(sc); e.fe = 16'(fe); e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_src1 = 4'd0; id_src2 = 4'd0; idex_dst = 4'd0;
    id_use1 = 1'b0; id_use2 = 1'b0; idex_mem_re = 1'b0;
    exmem_mem_re = 1'b0; exmem_mem_we = 1'b0; exmem_br_taken = 1'b0; exmem_hlt = 1'b0;
  endtask

  task automatic lduse_in(input logic [3:0] dst);
    idex_mem_re = 1'b1; idex_dst = dst; id_use1 = 1'b1; id_src1 = dst;
  endtask

  // One-cycle reset pulse asserted mid-cycle; outputs must drop at once.
  task automatic do_reset(input int sel, input string name);
    rst = 1'b1;
    exp(sel, NONE, 0, 0, name);
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear();
    step(); exp(0, NONE, 0, 0, "reset_a");
    step(); exp(2, NONE, 0, 0, "reset_c");
    step(); rst = 1'b0;

    // Load-use on A
    lduse_in(4'd3);                  exp(0, LU,   0, 0, "lduse_src1"); step();
    clear();                         exp(0, NONE, 1, 0, "lduse_done"); step();
    lduse_in(4'd0);                  exp(0, NONE, 1, 0, "lduse_r0");   step();
    clear(); idex_mem_re = 1'b1; idex_dst = 4'd5; id_use2 = 1'b1; id_src2 = 4'd5;
                                     exp(0, LU,   1, 0, "lduse_src2"); step();
    clear(); idex_mem_re = 1'b1; idex_dst = 4'd5; id_src1 = 4'd5;
                                     exp(0, NONE, 2, 0, "no_use1");    step();
    clear();

    // Memory stall on A (MEM_LAT=3)
    do_reset(0, "rst_mem_a");
    exmem_mem_re = 1'b1;             exp(0, MS,   0, 0, "mem_c0");     step();
                                     exp(0, MS,   1, 0, "mem_c1");     step();
                                     exp(0, NONE, 2, 0, "mem_release"); step();
    clear();                         exp(0, NONE, 2, 0, "mem_run");    step();
    exmem_mem_we = 1'b1;             exp(0, MS,   2, 0, "st_c0");      step();
    exmem_br_taken = 1'b1;           exp(0, MS,   3, 0, "st_br_ign");  step();
    exmem_hlt = 1'b1; lduse_in(4'd9);
                                     exp(0, LU,   4, 0, "st_rel_lduse"); step();
    clear();                         exp(0, NONE, 5, 0, "st_after");   step();

    // No memory stall with MEM_LAT=1 (B)
    do_reset(1, "rst_b");
    exmem_mem_re = 1'b1;             exp(1, NONE, 0, 0, "lat1_mem");   step();
    lduse_in(4'd7);                  exp(1, LU,   0, 0, "lat1_lduse"); step();
    clear();                         exp(1, NONE, 1, 0, "lat1_after"); step();

    // Taken branch on A
    do_reset(0, "rst_br");
    exmem_br_taken = 1'b1;           exp(0, BR,   0, 0, "br_taken");   step();
    clear();                         exp(0, NONE, 0, 1, "br_after");   step();
    exmem_br_taken = 1'b1; lduse_in(4'd2);
                                     exp(0, BR,   0, 1, "br_over_lduse"); step();
    clear();                         exp(0, NONE, 0, 2, "br_after2");  step();

    // Halt on A
    do_reset(0, "rst_hlt");
    exmem_hlt = 1'b1; exmem_mem_we = 1'b1; exmem_br_taken = 1'b1;
                                     exp(0, HTR,  0, 0, "hlt_wins");   step();
    clear(); exmem_br_taken = 1'b1; exmem_mem_re = 1'b1;
                                     exp(0, HT,   1, 0, "halted_1");   step();
    clear();                         exp(0, HT,   2, 0, "halted_2");   step();
    exmem_br_taken = 1'b1;           exp(0, HT,   3, 0, "halted_br");  step();
    clear();
    do_reset(0, "rst_from_halt");
                                     exp(0, NONE, 0, 0, "run_after_halt"); step();

    // Reset in the middle of a long wait (C, MEM_LAT=8)
    do_reset(2, "rst_c");
    exmem_mem_re = 1'b1;             exp(2, MS,   0, 0, "lat8_c0");    step();
                                     exp(2, MS,   1, 0, "lat8_c1");    step();
                                     exp(2, MS,   2, 0, "lat8_c2");    step();
    do_reset(2, "rst_midwait");
    for (int i = 0; i < 7; i++) begin
      exp(2, MS, i, 0, $sformatf("lat8_full_%0d", i)); step();
    end
                                     exp(2, NONE, 7, 0, "lat8_release"); step();
    clear();                         exp(2, NONE, 7, 0, "lat8_run");   step();

    // Counter saturation on C (4-bit)
    do_reset(2, "rst_sat");
    lduse_in(4'd4);
    for (int i = 0; i < 20; i++) begin
      exp(2, LU, (i > 15) ? 15 : i, 0, $sformatf("sat_%0d", i)); step();
    end
    clear();                         exp(2, NONE, 15, 0, "sat_hold");  step();

    step(); step();
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
